// File: rtl/sphere_feeder.sv
// Sphere table feeder: holds a small register table of spheres and hands them one at a
// time to the ray tracer, counting finished intersections until the pixel's sweep completes.
module sphere_feeder #(
    parameter int NUM_SPHERES = 4,
    parameter int DATA_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pixel_start,
    input  logic                     next_sphere,
    input  logic [1:0]               index,
    input  logic                     finished,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_addr,
    input  logic [1:0]               cfg_field,
    input  logic [DATA_W-1:0]        cfg_data,
    output logic                     valid,
    output logic signed [DATA_W-1:0] sphere_x,
    output logic signed [DATA_W-1:0] sphere_y,
    output logic signed [DATA_W-1:0] sphere_z,
    output logic [DATA_W-1:0]        sphere_r,
    output logic                     busy,
    output logic                     sweep_done,
    output logic                     index_err
);
    typedef enum logic [2:0] {IDLE, ARMED, FETCH, PRESENT, WAIT_DONE} state_t;

    localparam logic [2:0] NUM_L = 3'(NUM_SPHERES);

    state_t state, state_nx;
    logic [2:0] count;
    logic [1:0] idx_q;
    logic [NUM_SPHERES-1:0][3:0][DATA_W-1:0] tbl;
    logic [3:0][DATA_W-1:0] fetch_row;
    logic req_ok, done_last;

    assign req_ok    = next_sphere && ({1'b0, index} < NUM_L);
    assign done_last = finished && ((count + 3'd1) == NUM_L);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (pixel_start) state_nx = ARMED;
            ARMED:     if (req_ok) state_nx = FETCH;
            FETCH:     state_nx = PRESENT;
            PRESENT:   state_nx = WAIT_DONE;
            WAIT_DONE: if (finished) state_nx = done_last ? IDLE : ARMED;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        valid = (state == PRESENT);
    end

    // Table writes are accepted in every state; fetch reads the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            tbl <= '0;
        end else if (cfg_we) begin
            for (int e = 0; e < NUM_SPHERES; e++)
                if (cfg_addr == 2'(e)) tbl[e][cfg_field] <= cfg_data;
        end
    end

    always_comb begin
        fetch_row = '0;
        for (int e = 0; e < NUM_SPHERES; e++)
            if (idx_q == 2'(e)) fetch_row = tbl[e];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            idx_q      <= '0;
            index_err  <= 1'b0;
            sweep_done <= 1'b0;
            sphere_x   <= '0;
            sphere_y   <= '0;
            sphere_z   <= '0;
            sphere_r   <= '0;
        end else begin
            sweep_done <= (state == WAIT_DONE) && done_last;
            if (state == IDLE && pixel_start) count <= '0;
            if (state == WAIT_DONE && finished) count <= count + 3'd1;
            if (state == ARMED && next_sphere) begin
                if (req_ok) idx_q <= index;
                else        index_err <= 1'b1;
            end
            if (state == FETCH) begin
                sphere_x <= fetch_row[0];
                sphere_y <= fetch_row[1];
                sphere_z <= fetch_row[2];
                sphere_r <= fetch_row[3];
            end
        end
    end
endmodule

// File: tb/tb_sphere_feeder.sv
// Scoreboard bench: two feeders (4 and 3 entries) share stimulus; a transaction-level model
// predicts valid/sweep_done cycles and output values, a negedge monitor compares.
module tb_sphere_feeder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, pixel_start, next_sphere, finished, cfg_we;
    logic [1:0]  index, cfg_addr, cfg_field;
    logic [15:0] cfg_data;

    logic        o_valid[2], o_busy[2], o_done[2], o_err[2];
    logic [15:0] o_x[2], o_y[2], o_z[2], o_r[2];

    sphere_feeder #(.NUM_SPHERES(4), .DATA_W(16)) dut4 (
        .clk(clk), .rst(rst), .pixel_start(pixel_start), .next_sphere(next_sphere),
        .index(index), .finished(finished), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_field(cfg_field), .cfg_data(cfg_data), .valid(o_valid[0]),
        .sphere_x(o_x[0]), .sphere_y(o_y[0]), .sphere_z(o_z[0]), .sphere_r(o_r[0]),
        .busy(o_busy[0]), .sweep_done(o_done[0]), .index_err(o_err[0]));

    sphere_feeder #(.NUM_SPHERES(3), .DATA_W(16)) dut3 (
        .clk(clk), .rst(rst), .pixel_start(pixel_start), .next_sphere(next_sphere),
        .index(index), .finished(finished), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_field(cfg_field), .cfg_data(cfg_data), .valid(o_valid[1]),
        .sphere_x(o_x[1]), .sphere_y(o_y[1]), .sphere_z(o_z[1]), .sphere_r(o_r[1]),
        .busy(o_busy[1]), .sweep_done(o_done[1]), .index_err(o_err[1]));

    // Model: mode 0=idle, 1=armed, 2=sphere in flight (age counts edges since acceptance)
    int          m_mode[2], m_age[2], m_cnt[2];
    bit          m_err[2];
    int          m_idx[2];
    logic [15:0] m_tbl[2][4][4];
    logic [15:0] m_out[2][4];
    int          vq0[$], vq1[$], sq0[$], sq1[$];

    int cyc = 0, n_vec = 0, n_cmp = 0, n_err = 0;
    bit started = 0, fin_req = 0;

    task automatic model_step(input int k, input int n);
        if (rst) begin
            m_mode[k] = 0; m_age[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_idx[k] = 0;
            for (int a = 0; a < 4; a++) begin
                m_out[k][a] = '0;
                for (int f = 0; f < 4; f++) m_tbl[k][a][f] = '0;
            end
            return;
        end
        case (m_mode[k])
            0: if (pixel_start) begin m_mode[k] = 1; m_cnt[k] = 0; end
            1: if (next_sphere) begin
                   if (int'(index) < n) begin m_mode[k] = 2; m_age[k] = 0; m_idx[k] = int'(index); end
                   else m_err[k] = 1;
               end
            default: begin
                if (m_age[k] == 0) begin
                    for (int f = 0; f < 4; f++) m_out[k][f] = m_tbl[k][m_idx[k]][f];
                    if (k == 0) vq0.push_back(cyc); else vq1.push_back(cyc);
                    m_age[k] = 1;
                end else if (m_age[k] == 1) begin
                    m_age[k] = 2;
                end else if (finished) begin
                    m_cnt[k]++;
                    if (m_cnt[k] == n) begin
                        m_mode[k] = 0;
                        if (k == 0) sq0.push_back(cyc); else sq1.push_back(cyc);
                    end else m_mode[k] = 1;
                end
            end
        endcase
        if (cfg_we && int'(cfg_addr) < n) m_tbl[k][cfg_addr][cfg_field] = cfg_data;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_step(0, 4);
        model_step(1, 3);
        started = 1;
        n_vec++;
        #1;
    endtask

    task automatic drive(input bit r, input bit ps, input bit ns, input int idx, input bit fin,
                         input bit we, input int addr, input int fld, input logic [15:0] d);
        rst = r; pixel_start = ps; next_sphere = ns; index = 2'(idx); finished = fin;
        cfg_we = we; cfg_addr = 2'(addr); cfg_field = 2'(fld); cfg_data = d;
        step();
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) drive(0, 0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic round(input int idx);
        drive(0, 0, 1, idx, 0, 0, 0, 0, '0);
        idle(3);
        drive(0, 0, 0, 0, 1, 0, 0, 0, '0);
        idle(1);
    endtask

    task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", name, k, cyc, act, exp);
        end
    endtask

    task automatic check(input int k);
        bit vexp, sexp;
        vexp = 0; sexp = 0;
        if (k == 0) begin
            if (vq0.size() > 0 && vq0[0] == cyc) begin vexp = 1; void'(vq0.pop_front()); end
            if (sq0.size() > 0 && sq0[0] == cyc) begin sexp = 1; void'(sq0.pop_front()); end
        end else begin
            if (vq1.size() > 0 && vq1[0] == cyc) begin vexp = 1; void'(vq1.pop_front()); end
            if (sq1.size() > 0 && sq1[0] == cyc) begin sexp = 1; void'(sq1.pop_front()); end
        end
        cmp("valid", k, 32'(o_valid[k]), 32'(vexp));
        cmp("sweep_done", k, 32'(o_done[k]), 32'(sexp));
        cmp("busy", k, 32'(o_busy[k]), 32'(m_mode[k] != 0));
        cmp("index_err", k, 32'(o_err[k]), 32'(m_err[k]));
        cmp("sphere_x", k, 32'(o_x[k]), 32'(m_out[k][0]));
        cmp("sphere_y", k, 32'(o_y[k]), 32'(m_out[k][1]));
        cmp("sphere_z", k, 32'(o_z[k]), 32'(m_out[k][2]));
        cmp("sphere_r", k, 32'(o_r[k]), 32'(m_out[k][3]));
    endtask

    always @(negedge clk) begin
        if (started) begin
            check(0);
            check(1);
        end
        if (fin_req) begin
            cmp("leftover_valid", 0, 32'(vq0.size() + vq1.size()), 32'd0);
            cmp("leftover_sweep", 0, 32'(sq0.size() + sq1.size()), 32'd0);
        end
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, '0);
        drive(1, 0, 0, 0, 0, 1, 1, 1, 16'h1234);
        // load entry 1 = (5, -3, 100, 10) and run a full sweep
        drive(0, 0, 0, 0, 0, 1, 1, 0, 16'd5);
        drive(0, 0, 0, 0, 0, 1, 1, 1, 16'hFFFD);
        drive(0, 0, 0, 0, 0, 1, 1, 2, 16'd100);
        drive(0, 0, 0, 0, 0, 1, 1, 3, 16'd10);
        drive(0, 0, 0, 0, 0, 1, 2, 0, 16'hABCD);
        drive(0, 0, 0, 0, 0, 1, 3, 2, 16'h7777);
        drive(0, 0, 1, 1, 1, 0, 0, 0, '0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, '0);
        round(1);
        round(3);
        round(0);
        round(2);
        round(0);
        idle(2);
        // radius write while entry 0 waits for finished, then refetch
        drive(0, 1, 0, 0, 0, 0, 0, 0, '0);
        drive(0, 0, 1, 0, 0, 0, 0, 0, '0);
        idle(3);
        drive(0, 0, 0, 0, 0, 1, 0, 3, 16'd7);
        drive(0, 1, 1, 2, 0, 0, 0, 0, '0);
        drive(0, 0, 0, 0, 1, 0, 0, 0, '0);
        drive(0, 0, 0, 0, 1, 0, 0, 0, '0);
        round(0);
        // same-cycle write and fetch of entry 1
        drive(0, 0, 1, 1, 0, 0, 0, 0, '0);
        drive(0, 0, 0, 0, 0, 1, 1, 0, 16'h0042);
        idle(2);
        drive(0, 0, 0, 0, 1, 0, 0, 0, '0);
        // reset mid-sweep, then a fresh sweep needs all spheres again
        drive(0, 0, 1, 1, 0, 0, 0, 0, '0);
        idle(2);
        drive(1, 0, 0, 0, 0, 1, 0, 0, 16'hFFFF);
        drive(0, 1, 0, 0, 0, 0, 0, 0, '0);
        round(0); round(1); round(2); round(2); round(1);
        idle(2);
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            drive(r < 2, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                  int'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 16'($urandom));
        end
        idle(6);
        fin_req = 1;
        @(posedge clk);
        #1;
        fin_req = 0;
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sphere_feeder.md
SPHERE_FEEDER -- requirements
Module: sphere_feeder

Interface
REQ-001 SHALL have parameter NUM_SPHERES, default 4, number of table entries (1..4).
REQ-002 SHALL have parameter DATA_W, default 16, width of each sphere field.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 pixel_start  in  1  one-cycle pulse; begins a sphere sweep for a new pixel.
REQ-006 next_sphere  in  1  tracer request for sphere data.
REQ-007 index  in  2  sphere index requested by tracer, sampled with next_sphere.
REQ-008 finished  in  1  one-cycle pulse from intersection unit; current sphere done.
REQ-009 cfg_we  in  1  table write strobe.
REQ-010 cfg_addr  in  2  table entry to write.
REQ-011 cfg_field  in  2  field select: 0=x, 1=y, 2=z, 3=radius.
REQ-012 cfg_data  in  DATA_W  write data.
REQ-013 valid  out  1  one-cycle pulse; sphere outputs hold requested sphere.
REQ-014 sphere_x, sphere_y, sphere_z  out  DATA_W each  signed centre coordinates.
REQ-015 sphere_r  out  DATA_W  unsigned radius.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 sweep_done  out  1  one-cycle pulse when NUM_SPHERES spheres have finished.
REQ-018 index_err  out  1  sticky flag; requested index >= NUM_SPHERES.

Function
REQ-019 SHALL hold table of NUM_SPHERES x 4 fields, DATA_W bits each, in registers.
REQ-020 cfg_we=1 SHALL write cfg_data into entry cfg_addr, field cfg_field at next edge, in any state; cfg_addr >= NUM_SPHERES ignored.
REQ-021 SHALL implement FSM states IDLE, ARMED, FETCH, PRESENT, WAIT_DONE.
REQ-022 IDLE: pixel_start=1 -> ARMED, sphere counter cleared to 0; else stay.
REQ-023 ARMED: next_sphere=1 with index < NUM_SPHERES -> FETCH, index latched; next_sphere=1 with index >= NUM_SPHERES -> index_err set, stay ARMED; else stay.
REQ-024 FETCH: latched entry copied into sphere_x/y/z/r output registers; -> PRESENT.
REQ-025 PRESENT: valid=1 for exactly this cycle; -> WAIT_DONE unconditionally.
REQ-026 Request-to-valid latency SHALL be 2 cycles (next_sphere sampled at edge N, valid high in cycle after edge N+1).
REQ-027 WAIT_DONE: finished=1 -> counter+1; new count == NUM_SPHERES -> sweep_done pulse, -> IDLE; else -> ARMED.
REQ-028 Counter SHALL be 3 bits wide; never wraps, cleared only by pixel_start in IDLE or reset.
REQ-029 Sphere outputs SHALL hold last fetched values until next FETCH; table writes during PRESENT/WAIT_DONE do not alter them.
REQ-030 cfg write and FETCH of same entry in same cycle: FETCH SHALL capture old value.
REQ-031 pixel_start outside IDLE SHALL be ignored.
REQ-032 finished outside WAIT_DONE SHALL be ignored.
REQ-033 next_sphere outside ARMED SHALL be ignored (no queuing).
REQ-034 finished in same cycle as pixel_start: both evaluated per current state only.
REQ-035 valid, sweep_done SHALL never be high in same cycle.

Reset
REQ-036 rst=1 SHALL force IDLE, counter=0, valid=0, sweep_done=0, busy=0, index_err=0, sphere outputs=0, and clear all table entries to 0.
REQ-037 rst SHALL take priority over cfg_we and all other inputs, including mid-sweep.
REQ-038 index_err SHALL clear only on reset.

Verification
REQ-039 Load entry 1 = (x=5, y=-3, z=100, r=10); pixel_start; next_sphere, index=1 -> valid pulse 2 cycles later, outputs 5/-3/100/10, busy=1.
REQ-040 Full sweep NUM_SPHERES=4: four request/finished rounds -> sweep_done pulse one cycle after 4th finished, state IDLE, busy=0.
REQ-041 ARMED, next_sphere with index=3, NUM_SPHERES=3 -> no valid, index_err=1 and stays 1, FSM remains ARMED and accepts index=0 next.
REQ-042 cfg write entry 0 radius=7 during WAIT_DONE of entry 0 -> sphere_r unchanged until next FETCH, which shows 7.
REQ-043 rst asserted in WAIT_DONE after 2 finished -> IDLE, counter=0, table zero; new sweep needs 4 finished for sweep_done.
REQ-044 finished and next_sphere pulsed in ARMED/IDLE respectively out of order -> ignored, no valid, no count change.
